// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between NUM_REQ
//            requesters; latch, execute one cycle, hold tagged response.
// Options  : ALU_ARB_ILLEGAL_OP_EN - flag ops outside AND/OR/ADD/SUB as errors
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [4*NUM_REQ-1:0]    req_op_i,
    input  logic [XLEN*NUM_REQ-1:0] req_a_i,
    input  logic [XLEN*NUM_REQ-1:0] req_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [XLEN-1:0]         rsp_data_o,
    output logic                    rsp_zero_o,
    output logic                    rsp_err_o,
    output logic [3:0]              alu_op_o,
    output logic [XLEN-1:0]         alu_a_o,
    output logic [XLEN-1:0]         alu_b_o,
    input  logic [XLEN-1:0]         alu_c_i,
    input  logic                    alu_zero_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [ID_W-1:0]   r_id;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_zero;

    logic              w_gnt_found;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_accept;
    logic [3:0]        w_sel_op;
    logic [XLEN-1:0]   w_sel_a;
    logic [XLEN-1:0]   w_sel_b;

    // First pass covers requesters at/after the pointer, second pass wraps around.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_found && req_valid_i[k] && (ID_W'(k) >= r_rr_ptr)) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = ID_W'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_found && req_valid_i[k]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = ID_W'(k);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_gnt_found && !rst;

    always_comb begin
        req_ready_o = '0;
        w_sel_op    = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = w_accept && (w_gnt_id == ID_W'(k));
            if (w_gnt_id == ID_W'(k)) begin
                w_sel_op = req_op_i[4*k +: 4];
                w_sel_a  = req_a_i[XLEN*k +: XLEN];
                w_sel_b  = req_b_i[XLEN*k +: XLEN];
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic r_rsp_err;
    logic w_op_illegal;
    assign w_op_illegal = (r_op != 4'b0000) && (r_op != 4'b0001) &&
                          (r_op != 4'b0010) && (r_op != 4'b0110);
    assign rsp_err_o    = r_rsp_err;
`else
    assign rsp_err_o    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_op    <= w_sel_op;
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_gnt_id;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    r_rsp_data  <= w_op_illegal ? '0 : alu_c_i;
                    r_rsp_zero  <= w_op_illegal ? 1'b0 : alu_zero_i;
                    r_rsp_err   <= w_op_illegal;
`else
                    r_rsp_data  <= alu_c_i;
                    r_rsp_zero  <= alu_zero_i;
`endif
                end
                S_RESP: begin
                    // Pointer moves past the requester just served, only on handshake.
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_rr_ptr    <= (r_rsp_id == c_last_id) ? '0 : r_rsp_id + ID_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_op_o    = r_op;
    assign alu_a_o     = r_a;
    assign alu_b_o     = r_b;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_zero_o  = r_rsp_zero;

endmodule
`default_nettype wire
